// File: rtl/systolic_west_feeder.sv
// systolic_west_feeder
// Drives the west edge of the PE grid. Each accepted N-lane row vector is
// skewed so that lane i leaves i cycles later than lane 0, forming the
// diagonal wavefront the array consumes. One start pulse runs one pass:
// k_len vectors are fed, N zero vectors flush the skew, and done pulses once.
// Optional feature macro: FEEDER_UNDERRUN_EN adds a sticky underrun output.
module systolic_west_feeder #(
    parameter int DATA_BIT = 8,
    parameter int N        = 4,
    parameter int CNT_BIT  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_BIT-1:0]    k_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*DATA_BIT-1:0] in_data,
    output logic [N*DATA_BIT-1:0] out_data,
    output logic                  out_valid,
    output logic                  busy,
`ifdef FEEDER_UNDERRUN_EN
    output logic                  underrun,
`endif
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Flush counter only has to count 0..N-1.
    localparam int FLUSH_BIT = (N > 1) ? $clog2(N) : 1;

    state_t                 state_reg;
    logic [CNT_BIT-1:0]     remaining_reg;
    logic [FLUSH_BIT-1:0]   flush_cnt_reg;
    logic                   in_ready_reg;
    logic                   busy_reg;
    logic                   done_reg;

    logic                   accept;
    logic                   shift_en;
    logic [N*DATA_BIT-1:0]  shift_data;
    logic [N-1:0]           lane_tag;

    // In FEED the feeder is always ready, so a valid beat is an accepted beat.
    assign accept     = (state_reg == FEED) && in_valid;
    // The skew chains move on every FEED/FLUSH cycle, even on underruns, so
    // the wavefront timing depends only on cycle count.
    assign shift_en   = (state_reg == FEED) || (state_reg == FLUSH);
    // Underrun and flush cycles push an all-zero vector with tag 0.
    assign shift_data = accept ? in_data : '0;

    // Pass sequencer; in_ready/busy/done are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            flush_cnt_reg <= '0;
            in_ready_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        busy_reg <= 1'b1;
                        if (k_len != '0) begin
                            state_reg     <= FEED;
                            remaining_reg <= k_len;
                            in_ready_reg  <= 1'b1;
                        end else begin
                            // Empty pass: report completion straight away.
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                FEED: begin
                    if (in_valid) begin
                        remaining_reg <= remaining_reg - 1'b1;
                        if (remaining_reg == CNT_BIT'(1)) begin
                            state_reg     <= FLUSH;
                            in_ready_reg  <= 1'b0;
                            flush_cnt_reg <= '0;
                        end
                    end
                end
                FLUSH: begin
                    flush_cnt_reg <= flush_cnt_reg + 1'b1;
                    if (flush_cnt_reg == FLUSH_BIT'(N - 1)) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg    <= IDLE;
                    in_ready_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                end
            endcase
        end
    end

    // Lane gi is a chain of gi+1 data/tag registers; its last stage drives
    // the lane output, giving lane gi an extra delay of gi cycles.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            logic [DATA_BIT-1:0] stage_data_reg [0:gi];
            logic                stage_tag_reg  [0:gi];

            // Shift the lane chain whenever the pass is feeding or flushing.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s <= gi; s++) begin
                        stage_data_reg[s] <= '0;
                        stage_tag_reg[s]  <= 1'b0;
                    end
                end else if (shift_en) begin
                    stage_data_reg[0] <= shift_data[gi*DATA_BIT +: DATA_BIT];
                    stage_tag_reg[0]  <= accept;
                    for (int s = 1; s <= gi; s++) begin
                        stage_data_reg[s] <= stage_data_reg[s-1];
                        stage_tag_reg[s]  <= stage_tag_reg[s-1];
                    end
                end
            end

            assign out_data[gi*DATA_BIT +: DATA_BIT] = stage_data_reg[gi];
            assign lane_tag[gi]                       = stage_tag_reg[gi];
        end
    endgenerate

`ifdef FEEDER_UNDERRUN_EN
    logic underrun_reg;

    // Sticky flag: any FEED cycle without a vector; cleared when a pass starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_reg <= 1'b0;
        end else if ((state_reg == IDLE) && start) begin
            underrun_reg <= 1'b0;
        end else if ((state_reg == FEED) && !in_valid) begin
            underrun_reg <= 1'b1;
        end
    end

    assign underrun = underrun_reg;
`endif

    assign in_ready  = in_ready_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    // Valid while any lane output holds an accepted element.
    assign out_valid = |lane_tag;

endmodule

// File: tb/tb_systolic_west_feeder.sv
// Bench for systolic_west_feeder: a queue-based model of the pass sequence
// and skew, checked every cycle on the falling edge, plus literal tables.
module tb_systolic_west_feeder;

    localparam int DATA_BIT = 8;
    localparam int N        = 4;
    localparam int CNT_BIT  = 8;
    localparam int W        = N * DATA_BIT;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [CNT_BIT-1:0] k_len = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [W-1:0]       in_data = '0;
    logic [W-1:0]       out_data;
    logic               out_valid;
    logic               busy;
    logic               done;
`ifdef FEEDER_UNDERRUN_EN
    logic               underrun;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    systolic_west_feeder #(.DATA_BIT(DATA_BIT), .N(N), .CNT_BIT(CNT_BIT)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .k_len    (k_len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_data (out_data),
        .out_valid(out_valid),
        .busy     (busy),
`ifdef FEEDER_UNDERRUN_EN
        .underrun (underrun),
`endif
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Lane i shows the i-th most recent vector pushed into the skew.
    typedef struct packed {
        logic [W-1:0] d;
        logic         t;
    } shift_t;

    shift_t hist[$];
    int     m_phase = 0;   // 0 idle, 1 feed, 2 flush, 3 done
    int     m_rem   = 0;
    int     m_fl    = 0;
    bit     m_und   = 1'b0;

    task automatic push_vec(input logic [W-1:0] d, input logic t);
        shift_t e;
        e.d = d;
        e.t = t;
        hist.push_back(e);
        if (hist.size() > N) void'(hist.pop_front());
    endtask

    always @(negedge clk) begin
        logic [W-1:0] exp_data;
        logic         exp_valid;
        shift_t       e;
        if (rst) begin
            hist.delete();
            m_phase = 0;
            m_rem   = 0;
            m_fl    = 0;
            m_und   = 1'b0;
        end
        exp_data  = '0;
        exp_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (hist.size() > i) begin
                e = hist[hist.size()-1-i];
                exp_data[i*DATA_BIT +: DATA_BIT] = e.d[i*DATA_BIT +: DATA_BIT];
                exp_valid = exp_valid | e.t;
            end
        end
        chk("model_out_data", 64'(out_data), 64'(exp_data));
        chk("model_out_valid", 64'(out_valid), 64'(exp_valid));
        chk("model_in_ready", 64'(in_ready), 64'(m_phase == 1));
        chk("model_busy", 64'(busy), 64'(m_phase != 0));
        chk("model_done", 64'(done), 64'(m_phase == 3));
`ifdef FEEDER_UNDERRUN_EN
        chk("model_underrun", 64'(underrun), 64'(m_und));
`endif
        if (!rst) begin
            case (m_phase)
                0: if (start) begin
                    m_und = 1'b0;
                    if (k_len != 0) begin m_phase = 1; m_rem = int'(k_len); end
                    else m_phase = 3;
                end
                1: begin
                    if (in_valid) begin
                        push_vec(in_data, 1'b1);
                        m_rem--;
                        if (m_rem == 0) begin m_phase = 2; m_fl = 0; end
                    end else begin
                        push_vec('0, 1'b0);
                        m_und = 1'b1;
                    end
                end
                2: begin
                    push_vec('0, 1'b0);
                    m_fl++;
                    if (m_fl == N) m_phase = 3;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [W-1:0] vec(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    task automatic drive(input logic st, input logic [CNT_BIT-1:0] k, input logic v, input logic [W-1:0] d);
        @(posedge clk);
        #1;
        start    = st;
        k_len    = k;
        in_valid = v;
        in_data  = d;
    endtask

    // Scenario-2 pass; optional stray start in cycle 4 and optional reset cycle.
    task automatic run_s2(input bit extra_start, input int rst_cyc);
        int l0 [10];
        int l3 [10];
        logic st;
        logic v;
        logic [W-1:0] d;
        int base;
        l0 = '{0, 0, 1, 5, 9, 0, 0, 0, 0, 0};
        l3 = '{0, 0, 0, 0, 0, 4, 8, 12, 0, 0};
        for (int c = 0; c < 10; c++) begin
            st   = (c == 0) || (extra_start && c == 4);
            v    = (c >= 1) && (c <= 3);
            base = 4 * (c - 1);
            d    = v ? vec(base + 1, base + 2, base + 3, base + 4) : '0;
            drive(st, 8'd3, v, d);
            if (rst_cyc >= 0 && c == rst_cyc) rst = 1'b1;
            if (rst_cyc >= 0 && c == rst_cyc + 2) rst = 1'b0;
            #1;
            if (rst_cyc >= 0 && c >= rst_cyc) begin
                chk("s6_out_data", 64'(out_data), 64'd0);
                chk("s6_done", 64'(done), 64'd0);
                chk("s6_busy", 64'(busy), 64'd0);
                chk("s6_out_valid", 64'(out_valid), 64'd0);
            end else begin
                chk("s2_lane0", 64'(out_data[7:0]), 64'(l0[c]));
                chk("s2_lane3", 64'(out_data[31:24]), 64'(l3[c]));
                chk("s2_done", 64'(done), 64'(c == 8));
                chk("s2_busy", 64'(busy), 64'(c >= 1 && c <= 8));
                chk("s2_out_valid", 64'(out_valid), 64'(c >= 2 && c <= 7));
            end
`ifdef FEEDER_UNDERRUN_EN
            if (c >= 1) chk("s2_underrun_clear", 64'(underrun), 64'd0);
`endif
        end
    endtask

    initial begin
        int l0 [11];
        int l3 [11];
        logic v;
        logic [W-1:0] d;

        // Scenario 1: reset state, mid-pass reset, quiet after release.
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        drive(1'b0, 8'd0, 1'b0, '0);
        rst = 1'b0;
        drive(1'b1, 8'd2, 1'b0, '0);
        drive(1'b0, 8'd0, 1'b1, vec(7, 7, 7, 7));
        drive(1'b0, 8'd0, 1'b0, '0);
        rst = 1'b1;
        #1;
        chk("s1_mid_out_data", 64'(out_data), 64'd0);
        chk("s1_mid_busy", 64'(busy), 64'd0);
        chk("s1_mid_in_ready", 64'(in_ready), 64'd0);
        drive(1'b0, 8'd0, 1'b0, '0);
        drive(1'b0, 8'd0, 1'b0, '0);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, 8'd0, 1'b0, '0);
            #1;
            chk("s1_idle_data", 64'(out_data), 64'd0);
            chk("s1_idle_busy", 64'(busy), 64'd0);
        end

        // Scenario 2: basic pass.
        run_s2(1'b0, -1);

        // Scenario 3: underrun in cycle 2.
        l0 = '{0, 0, 1, 0, 5, 9, 0, 0, 0, 0, 0};
        l3 = '{0, 0, 0, 0, 0, 4, 0, 8, 12, 0, 0};
        for (int c = 0; c < 11; c++) begin
            v = (c == 1) || (c == 3) || (c == 4);
            case (c)
                1: d = vec(1, 2, 3, 4);
                3: d = vec(5, 6, 7, 8);
                4: d = vec(9, 10, 11, 12);
                default: d = '0;
            endcase
            drive(c == 0, 8'd3, v, d);
            #1;
            chk("s3_lane0", 64'(out_data[7:0]), 64'(l0[c]));
            chk("s3_lane3", 64'(out_data[31:24]), 64'(l3[c]));
            chk("s3_done", 64'(done), 64'(c == 9));
`ifdef FEEDER_UNDERRUN_EN
            chk("s3_underrun", 64'(underrun), 64'(c >= 3));
`endif
        end

        // Next start clears the sticky flag (checked inside run_s2).
        run_s2(1'b0, -1);

        // Scenario 4: empty pass.
        drive(1'b1, 8'd0, 1'b0, '0);
        #1;
        chk("s4_done_c0", 64'(done), 64'd0);
        drive(1'b0, 8'd0, 1'b0, '0);
        #1;
        chk("s4_done_c1", 64'(done), 64'd1);
        chk("s4_busy_c1", 64'(busy), 64'd1);
        chk("s4_in_ready_c1", 64'(in_ready), 64'd0);
        chk("s4_out_valid_c1", 64'(out_valid), 64'd0);
        drive(1'b0, 8'd0, 1'b0, '0);
        #1;
        chk("s4_done_c2", 64'(done), 64'd0);
        chk("s4_busy_c2", 64'(busy), 64'd0);

        // Scenario 5: stray start during the pass is ignored.
        run_s2(1'b1, -1);
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 8'd0, 1'b0, '0);
            #1;
            chk("s5_no_second_pass", 64'(busy), 64'd0);
        end

        // Scenario 6: reset during FLUSH, then a clean pass.
        run_s2(1'b0, 6);
        run_s2(1'b0, -1);

        repeat (3) drive(1'b0, 8'd0, 1'b0, '0);
        @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
